// File: rtl/lcd_init_sequencer.sv
// HD44780 4-bit power-on init sequencer that then forwards characters/commands to a byte writer.
// Optional feature macro LCD_AUTO_WRAP_EN: inserts 0xC0 after the 16th and 0x80 after the 32nd character.
module lcd_init_sequencer #(
   parameter int T_POWERUP = 750000,
   parameter int T_4MS     = 205000,
   parameter int T_100US   = 5000,
   parameter int T_40US    = 2000,
   parameter int T_CLEAR   = 82000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] iChar,
   input  logic       iCmd,
   input  logic       iChar_Valid,
   output logic       oChar_Ready,
   output logic [7:0] oData_BYTE,
   output logic       oRS,
   output logic       oNibble_Only,
   output logic       oByte_Valid,
   input  logic       iByte_Done,
   output logic       oInit_Done
);
   // Counter reload is N-1 so a wait lasts N cycles; N=0 behaves as N=1.
   localparam logic [19:0] LD_4MS   = (T_4MS   > 1) ? 20'(T_4MS   - 1) : 20'd0;
   localparam logic [19:0] LD_100US = (T_100US > 1) ? 20'(T_100US - 1) : 20'd0;
   localparam logic [19:0] LD_40US  = (T_40US  > 1) ? 20'(T_40US  - 1) : 20'd0;
   localparam logic [19:0] LD_CLEAR = (T_CLEAR > 1) ? 20'(T_CLEAR - 1) : 20'd0;
   // Power-up spends its first cycle arming the counter, hence N-2.
   localparam logic [19:0] LD_PWR   = (T_POWERUP > 2) ? 20'(T_POWERUP - 2) : 20'd0;
   localparam bit          PWR_SINGLE = (T_POWERUP <= 1);

   typedef enum logic [3:0] {
      PWR_WAIT, NIB3_A, NIB3_B, NIB3_C, NIB2, CFG, POST_WAIT, IDLE, SEND
   } state_t;

   state_t      state;
   state_t      retState;
   logic [19:0] waitCount;
   logic [1:0]  cfgIdx;
   logic        pwrArmed;
   logic        clearCmd;

`ifdef LCD_AUTO_WRAP_EN
   logic [4:0]  charCount;
   logic        wrapPending;
   logic [7:0]  wrapByte;
`endif

   function automatic logic [7:0] cfgByte(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h28;
         2'd1:    return 8'h06;
         2'd2:    return 8'h0C;
         default: return 8'h01;
      endcase
   endfunction

   // Clear-display and return-home need the long post-write wait.
   assign clearCmd = !oRS && !oNibble_Only && (oData_BYTE == 8'h01 || oData_BYTE == 8'h02);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= PWR_WAIT;
         retState     <= PWR_WAIT;
         waitCount    <= '0;
         cfgIdx       <= '0;
         pwrArmed     <= 1'b0;
         oChar_Ready  <= 1'b0;
         oData_BYTE   <= 8'h00;
         oRS          <= 1'b0;
         oNibble_Only <= 1'b0;
         oByte_Valid  <= 1'b0;
         oInit_Done   <= 1'b0;
`ifdef LCD_AUTO_WRAP_EN
         charCount    <= '0;
         wrapPending  <= 1'b0;
         wrapByte     <= 8'h00;
`endif
      end else begin
         case (state)
            PWR_WAIT: begin
               if (!pwrArmed) begin
                  pwrArmed  <= 1'b1;
                  waitCount <= LD_PWR;
               end else if (waitCount != '0) begin
                  waitCount <= waitCount - 20'd1;
               end
               if (PWR_SINGLE || (pwrArmed && waitCount == '0)) begin
                  state        <= NIB3_A;
                  oData_BYTE   <= 8'h03;
                  oRS          <= 1'b0;
                  oNibble_Only <= 1'b1;
                  oByte_Valid  <= 1'b1;
               end
            end
            NIB3_A, NIB3_B, NIB3_C, NIB2, CFG, SEND: begin
               if (oByte_Valid && iByte_Done) begin
                  oByte_Valid <= 1'b0;
                  state       <= POST_WAIT;
                  case (state)
                     NIB3_A: begin waitCount <= LD_4MS;   retState <= NIB3_B; end
                     NIB3_B: begin waitCount <= LD_100US; retState <= NIB3_C; end
                     NIB3_C: begin waitCount <= LD_40US;  retState <= NIB2;   end
                     NIB2: begin
                        waitCount <= LD_40US;
                        retState  <= CFG;
                        cfgIdx    <= 2'd0;
                     end
                     CFG: begin
                        waitCount <= clearCmd ? LD_CLEAR : LD_40US;
                        retState  <= (cfgIdx == 2'd3) ? IDLE : CFG;
                        cfgIdx    <= cfgIdx + 2'd1;
                     end
                     default: begin
                        waitCount <= clearCmd ? LD_CLEAR : LD_40US;
`ifdef LCD_AUTO_WRAP_EN
                        retState  <= wrapPending ? SEND : IDLE;
`else
                        retState  <= IDLE;
`endif
                     end
                  endcase
               end
            end
            POST_WAIT: begin
               if (waitCount != '0) begin
                  waitCount <= waitCount - 20'd1;
               end else begin
                  state <= retState;
                  oRS   <= 1'b0;
                  case (retState)
                     NIB3_B, NIB3_C: begin
                        oData_BYTE <= 8'h03; oNibble_Only <= 1'b1; oByte_Valid <= 1'b1;
                     end
                     NIB2: begin
                        oData_BYTE <= 8'h02; oNibble_Only <= 1'b1; oByte_Valid <= 1'b1;
                     end
                     CFG: begin
                        oData_BYTE <= cfgByte(cfgIdx); oNibble_Only <= 1'b0; oByte_Valid <= 1'b1;
                     end
`ifdef LCD_AUTO_WRAP_EN
                     SEND: begin
                        oData_BYTE   <= wrapByte;
                        oNibble_Only <= 1'b0;
                        oByte_Valid  <= 1'b1;
                        wrapPending  <= 1'b0;
                     end
`endif
                     default: begin
                        oChar_Ready <= 1'b1;
                        oInit_Done  <= 1'b1;
                     end
                  endcase
               end
            end
            IDLE: begin
               if (iChar_Valid && oChar_Ready) begin
                  oChar_Ready  <= 1'b0;
                  oData_BYTE   <= iChar;
                  oRS          <= ~iCmd;
                  oNibble_Only <= 1'b0;
                  oByte_Valid  <= 1'b1;
                  state        <= SEND;
`ifdef LCD_AUTO_WRAP_EN
                  // 16th char (count 15) moves to line 2; 32nd (count 31) homes to line 1 and wraps to 0.
                  if (!iCmd) begin
                     charCount <= charCount + 5'd1;
                     if (charCount[3:0] == 4'hF) begin
                        wrapPending <= 1'b1;
                        wrapByte    <= charCount[4] ? 8'h80 : 8'hC0;
                     end
                  end else if (iChar == 8'h01 || iChar == 8'h02) begin
                     charCount <= '0;
                  end
`endif
               end
            end
            default: state <= PWR_WAIT;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Self-checking bench for lcd_init_sequencer: init sequence, handshake, reset abort, random traffic.
`timescale 1ns/1ps
module tb_lcd_init_sequencer;
   localparam int P_PWR   = 20;
   localparam int P_4MS   = 8;
   localparam int P_100US = 4;
   localparam int P_40US  = 3;
   localparam int P_CLEAR = 10;
   localparam int BOUND   = 400;
   localparam int WR_LAT  = 5;

   typedef struct {
      logic [7:0] b;
      logic       rs;
      logic       nib;
      int         waitAfter;
   } wr_t;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] iChar = 8'h00;
   logic       iCmd = 1'b0;
   logic       iChar_Valid = 1'b0;
   logic       oChar_Ready;
   logic [7:0] oData_BYTE;
   logic       oRS;
   logic       oNibble_Only;
   logic       oByte_Valid;
   logic       oInit_Done;
   logic       doneW = 1'b0;
   logic       spurDone = 1'b0;
   logic       iByte_Done;

   int  assertions = 0;
   int  failures = 0;
   int  charsWritten = 0;
   wr_t expQ[$];

   logic [7:0] initB [8] = '{8'h03, 8'h03, 8'h03, 8'h02, 8'h28, 8'h06, 8'h0C, 8'h01};
   int         initW [8] = '{P_4MS, P_100US, P_40US, P_40US, P_40US, P_40US, P_40US, P_CLEAR};

   assign iByte_Done = doneW | spurDone;

   lcd_init_sequencer #(
      .T_POWERUP(P_PWR), .T_4MS(P_4MS), .T_100US(P_100US), .T_40US(P_40US), .T_CLEAR(P_CLEAR)
   ) dut (
      .Clock(Clock), .Reset(Reset), .iChar(iChar), .iCmd(iCmd), .iChar_Valid(iChar_Valid),
      .oChar_Ready(oChar_Ready), .oData_BYTE(oData_BYTE), .oRS(oRS), .oNibble_Only(oNibble_Only),
      .oByte_Valid(oByte_Valid), .iByte_Done(iByte_Done), .oInit_Done(oInit_Done)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertions++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Writer model: pulses done once the request has been seen for WR_LAT cycles.
   initial begin
      int wcnt;
      wcnt = 0;
      forever begin
         tick();
         if (doneW) begin
            doneW = 1'b0;
            wcnt = 0;
         end else if (oByte_Valid) begin
            wcnt++;
            if (wcnt == WR_LAT) doneW = 1'b1;
         end else begin
            wcnt = 0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic waitRise(output int gap);
      gap = 0;
      while (!oByte_Valid && gap < BOUND) begin
         tick();
         gap++;
      end
   endtask

   task automatic waitFall(output int hi, output bit stable);
      logic [7:0] d;
      logic r, n;
      d = oData_BYTE; r = oRS; n = oNibble_Only;
      hi = 0;
      stable = 1'b1;
      while (oByte_Valid && hi < BOUND) begin
         if (oData_BYTE !== d || oRS !== r || oNibble_Only !== n) stable = 1'b0;
         tick();
         hi++;
      end
   endtask

   task automatic waitReady(output int n);
      n = 0;
      while (!oChar_Ready && n < BOUND) begin
         tick();
         n++;
      end
   endtask

   task automatic expectWrite(input string tag, input wr_t w, input int gapExp, input bit doFall);
      int  gap, hi;
      bit  st;
      waitRise(gap);
      $display("write %s: data=%02h rs=%0b nib=%0b gap=%0d", tag, oData_BYTE, oRS, oNibble_Only, gap);
      check({tag, " gap"}, gap, gapExp);
      check({tag, " data"}, oData_BYTE, w.b);
      check({tag, " rs"}, oRS, w.rs);
      check({tag, " nib"}, oNibble_Only, w.nib);
      check({tag, " readyLow"}, oChar_Ready, 1'b0);
      if (doFall) begin
         waitFall(hi, st);
         check({tag, " validCycles"}, hi, WR_LAT);
         check({tag, " stable"}, st, 1'b1);
      end
   endtask

   task automatic checkReset(input string tag);
      check({tag, " valid"}, oByte_Valid, 1'b0);
      check({tag, " ready"}, oChar_Ready, 1'b0);
      check({tag, " initDone"}, oInit_Done, 1'b0);
      check({tag, " data"}, oData_BYTE, 8'h00);
      check({tag, " rs"}, oRS, 1'b0);
      check({tag, " nib"}, oNibble_Only, 1'b0);
   endtask

   // Init sequence from the table; the gap before write i is the wait after write i-1.
   task automatic initWrites(input int nWrites, input bit fallLast);
      int  gapExp;
      wr_t w;
      gapExp = P_PWR;
      for (int i = 0; i < nWrites; i++) begin
         w.b = initB[i]; w.rs = 1'b0; w.nib = (i < 4); w.waitAfter = initW[i];
         expectWrite("init", w, gapExp, (i < nWrites - 1) || fallLast);
         gapExp = initW[i];
      end
   endtask

   // Reference model: a write plus any line-change command it triggers.
   task automatic pushTxn(input logic [7:0] b, input logic cmd);
      wr_t w;
      w.b = b; w.rs = !cmd; w.nib = 1'b0;
      w.waitAfter = (cmd && (b == 8'h01 || b == 8'h02)) ? P_CLEAR : P_40US;
      expQ.push_back(w);
      if (!cmd) charsWritten++;
      else if (b == 8'h01 || b == 8'h02) charsWritten = 0;
`ifdef LCD_AUTO_WRAP_EN
      if (!cmd && charsWritten == 16) begin
         w.b = 8'hC0; w.rs = 1'b0; w.waitAfter = P_40US;
         expQ.push_back(w);
      end else if (!cmd && charsWritten == 32) begin
         w.b = 8'h80; w.rs = 1'b0; w.waitAfter = P_40US;
         expQ.push_back(w);
         charsWritten = 0;
      end
`else
      if (charsWritten > 1000) charsWritten = 0;
`endif
   endtask

   task automatic drainExpected(input string tag);
      int  gap, n;
      wr_t w;
      gap = 0;
      while (expQ.size() > 0) begin
         w = expQ.pop_front();
         expectWrite(tag, w, gap, 1'b1);
         gap = w.waitAfter;
      end
      waitReady(n);
      check({tag, " readyGap"}, n, gap);
   endtask

   task automatic sendTxn(input string tag, input logic [7:0] b, input logic cmd);
      check({tag, " readyBefore"}, oChar_Ready, 1'b1);
      iChar = b;
      iCmd = cmd;
      iChar_Valid = 1'b1;
      tick();
      iChar_Valid = 1'b0;
      pushTxn(b, cmd);
      drainExpected(tag);
   endtask

   initial begin
      int n;
      logic [7:0] rb;
      logic rc;

      // Request held high through reset and init must not be taken early.
      iChar = 8'h5A; iCmd = 1'b0; iChar_Valid = 1'b1;
      repeat (3) tick();
      checkReset("rst0");
      Reset = 1'b0;

      // Abort during the 0x06 write, two cycles into the handshake.
      initWrites(6, 1'b0);
      tick(); tick();
      Reset = 1'b1;
      tick();
      checkReset("rstMid");
      tick();
      Reset = 1'b0;

      initWrites(8, 1'b1);
      waitReady(n);
      check("init readyGap", n, P_CLEAR);
      check("init done", oInit_Done, 1'b1);

      // The still-held request is accepted at the first ready cycle with the current iChar.
      tick();
      iChar_Valid = 1'b0;
      pushTxn(8'h5A, 1'b0);
      drainExpected("held");

      // Done pulse with no write outstanding is ignored.
      spurDone = 1'b1;
      tick();
      spurDone = 1'b0;
      check("spur valid", oByte_Valid, 1'b0);
      check("spur ready", oChar_Ready, 1'b1);
      tick();

      sendTxn("char41", 8'h41, 1'b0);
      sendTxn("cmd01", 8'h01, 1'b1);

      for (int i = 0; i < 8; i++) begin
         rb = 8'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         if (rc && $urandom_range(0, 2) == 0) rb = 8'($urandom_range(1, 2));
         sendTxn("rand", rb, rc);
      end

`ifdef LCD_AUTO_WRAP_EN
      sendTxn("wrapClr", 8'h01, 1'b1);
      for (int i = 0; i < 17; i++) begin
         sendTxn("wrapChar", 8'($urandom_range(8'h20, 8'h7E)), 1'b0);
      end
`endif

      check("end initDone", oInit_Done, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule

// File: doc/lcd_init_sequencer.md
LCD_INIT_SEQUENCER -- requirements
Module: lcd_init_sequencer

Interface
REQ-001 The block SHALL have parameter T_POWERUP, default 750000, meaning cycles waited after reset before the first write (15 ms at 50 MHz).
REQ-002 The block SHALL have parameter T_4MS, default 205000, meaning cycles waited after the first 0x3 nibble.
REQ-003 The block SHALL have parameter T_100US, default 5000, meaning cycles waited after the second 0x3 nibble.
REQ-004 The block SHALL have parameter T_40US, default 2000, meaning post-write wait for ordinary commands and characters.
REQ-005 The block SHALL have parameter T_CLEAR, default 82000, meaning post-write wait after commands 0x01 and 0x02 (1.64 ms).
REQ-006 The block SHALL have port Clock, input, 1 bit: system clock.
REQ-007 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port iChar, input, 8 bits: character code, or command byte when iCmd=1.
REQ-009 The block SHALL have port iCmd, input, 1 bit: 1 = command (RS=0), 0 = character (RS=1).
REQ-010 The block SHALL have port iChar_Valid, input, 1 bit: upstream request.
REQ-011 The block SHALL have port oChar_Ready, output, 1 bit: request accepted in any cycle where iChar_Valid and oChar_Ready are both 1.
REQ-012 The block SHALL have port oData_BYTE, output, 8 bits: byte passed to the downstream LCD writer.
REQ-013 The block SHALL have port oRS, output, 1 bit: register select passed to the writer.
REQ-014 The block SHALL have port oNibble_Only, output, 1 bit: 1 = writer sends only oData_BYTE[3:0], as a single nibble.
REQ-015 The block SHALL have port oByte_Valid, output, 1 bit: write request to the writer.
REQ-016 The block SHALL have port iByte_Done, input, 1 bit: one-cycle pulse from the writer when the write completes.
REQ-017 The block SHALL have port oInit_Done, output, 1 bit: high once the init sequence has completed.

Function
REQ-018 The FSM SHALL use states PWR_WAIT, NIB3_A, NIB3_B, NIB3_C, NIB2, CFG, POST_WAIT, IDLE and SEND, with a single 20-bit down-counter shared for all waits.
REQ-019 PWR_WAIT SHALL count T_POWERUP cycles, then issue the nibble-only writes 0x3, 0x3, 0x3, 0x2, followed by waits of T_4MS, T_100US, T_40US and T_40US respectively.
REQ-020 CFG SHALL issue the full bytes 0x28, 0x06, 0x0C and 0x01 with RS=0, each followed by a T_40US wait, except 0x01, which is followed by T_CLEAR; oInit_Done SHALL rise in the cycle the FSM enters IDLE.
REQ-021 Write handshake: oData_BYTE, oRS and oNibble_Only SHALL be stable while oByte_Valid=1; oByte_Valid SHALL stay high until iByte_Done=1 and go low the following cycle, after which the post-write wait starts.
REQ-022 iByte_Done while oByte_Valid=0 SHALL be ignored.
REQ-023 oChar_Ready SHALL be 1 only in IDLE; while oChar_Ready=0, iChar_Valid SHALL have no effect, with no queuing and no data capture.
REQ-024 On acceptance, the block SHALL register iChar and iCmd, and SHALL assert oByte_Valid in the next cycle with oRS = ~iCmd and oNibble_Only=0.
REQ-025 After an accepted command 0x01 or 0x02, the post-write wait SHALL be T_CLEAR; after any other accepted write it SHALL be T_40US.
REQ-026 The wait counter SHALL load N-1 and the FSM SHALL exit when the counter reaches 0, giving exactly N cycles; a value of 0 SHALL be treated as 1.
REQ-027 Reset asserted mid-write or mid-wait SHALL abort the operation and restart the full init sequence from PWR_WAIT.

Reset
REQ-028 While Reset=1, the block SHALL hold oByte_Valid=0, oChar_Ready=0, oInit_Done=0, oData_BYTE=0x00, oRS=0, oNibble_Only=0, counter=0 and state=PWR_WAIT.
REQ-029 The first T_POWERUP count SHALL begin in the first cycle after Reset deasserts.

Configuration
REQ-030 Macro LCD_AUTO_WRAP_EN SHALL, when defined, add a 5-bit count of characters written.
REQ-031 With LCD_AUTO_WRAP_EN defined, after the 16th character the block SHALL insert command 0xC0 (T_40US), and after the 32nd it SHALL insert 0x80 (T_40US) and clear the count, holding oChar_Ready=0 during each insertion.
REQ-032 With LCD_AUTO_WRAP_EN defined, commands 0x01 and 0x02 SHALL clear the count.
REQ-033 With LCD_AUTO_WRAP_EN undefined, the block SHALL have no counter and insert no commands.

Verification (parameters 20/8/4/3/10; writer model answers iByte_Done 5 cycles after oByte_Valid)
REQ-034 The bench SHALL release Reset and check the write sequence 3,3,3,2 (nibble-only), then 28,06,0C,01 (RS=0), with gaps 8/4/3/3/3/3/3/10 cycles, then oInit_Done=1.
REQ-035 The bench SHALL send char 0x41 (iCmd=0) in IDLE and check oData_BYTE=0x41, oRS=1 and oByte_Valid held for 5 cycles, then oChar_Ready=1 exactly 3 cycles after the write completes.
REQ-036 The bench SHALL send command 0x01 and check a 10-cycle post wait before oChar_Ready=1.
REQ-037 The bench SHALL hold iChar_Valid=1 during init and check that no acceptance occurs and the first write after IDLE carries the iChar value present at that time.
REQ-038 The bench SHALL assert Reset during the 0x06 write and check that all outputs go to reset values and the sequence restarts at the 20-cycle wait.
REQ-039 With LCD_AUTO_WRAP_EN, the bench SHALL send 17 characters and check that 0xC0 (RS=0) is issued between the 16th and 17th.
